mem_stage: RTL
==============

# mem_stage

Parametrised memory-access pipeline stage of the five-stage CPU, between execute and writeback. Decodes single-data-transfer instructions (word/byte, load/store), drives a data-memory request/grant/response interface with byte enables, stalls upstream until the access completes, and registers ALU result, load data, writeback address and control for the writeback stage. Non-memory instructions pass through in one cycle.

## Interface
Parameters:
- DATA_W, 32, datapath width; multiple of 8, at least 16
- ADDR_W, 32, data-memory address width
- REG_W, 4, register-file address width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- alu_data_i  in  DATA_W  ALU result / effective address
- store_data_i  in  DATA_W  store data (Rd value)
- inst_i  in  32  instruction in MEM
- valid_i  in  1  instruction valid
- do_write_i  in  1  register writeback enable from EX
- flush_i  in  1  squash instruction currently in MEM
- stall_o  out  1  hold EX/MEM inputs this cycle
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  ADDR_W  lane-aligned address
- dmem_wdata_o  out  DATA_W  store data
- dmem_be_o  out  DATA_W/8  byte enables
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  DATA_W  read data
- alu_data_o  out  DATA_W  registered ALU result
- mem_data_o  out  DATA_W  registered, lane-extracted load data
- wb_addr_o  out  REG_W  registered inst_i[15:12]
- valid_o, do_write_o, load_o, flush_o  out  1 each  registered control

## Operation
- Decode: mem op = inst_i[27:26]==2'b01; L = inst_i[20]; B = inst_i[22]. Active op = valid_i & mem op & ~flush_i.
- LB = log2(DATA_W/8). dmem_addr_o = alu_data_i with low LB bits zeroed.
- Word: be all ones, wdata = store_data_i, load data unmodified.
- Byte: be = one-hot at alu_data_i[LB-1:0]; wdata = store_data_i[7:0] replicated to all lanes; load = selected lane, zero-extended.
- FSM IDLE / WAIT_RSP / DRAIN:
  - IDLE: dmem_req_o = active op (combinational). Store + gnt: complete. Load + gnt: go WAIT_RSP. No gnt: remain, request held.
  - WAIT_RSP: req low. rvalid: complete, go IDLE. flush_i while waiting: go DRAIN.
  - DRAIN: req low; rvalid discarded, go IDLE, registered valid_o = 0.
- stall_o = (IDLE & active op & ~(store & gnt)) | WAIT_RSP | DRAIN.
- Output registers update every cycle stall_o is low. valid_o <= valid_i & ~flush_i; do_write_o <= do_write_i & valid_i & ~flush_i & ~(mem op & ~L); load_o <= that valid & mem op & L; flush_o <= flush_i; mem_data_o updates only on completing load.
- While stall_o high, valid_o/do_write_o/load_o register 0 (bubble); alu_data_o, wb_addr_o, mem_data_o hold.
- Upstream must keep inputs stable while stall_o high; flush_i may change.

## Timing
- Reset (async): state IDLE, every output register 0, dmem_req_o 0, stall_o 0. Reset during WAIT_RSP/DRAIN abandons the access; later rvalid ignored in IDLE.
- Non-memory or granted store: outputs valid one edge after input, zero stall.
- Load, gnt at cycle 0, rvalid at cycle N (N >= 1): stall_o high cycles 0..N-1, outputs valid at edge ending cycle N.
- rvalid in IDLE: ignored. gnt outside IDLE: ignored.
- flush_i in IDLE with pending request: no request, no stall, bubble out.
- One outstanding access; no new request before response or drain.

## Structure
- cpu_pkg: instruction field positions (27:26, 22, 20, 15:12), mem-op opcode 2'b01, FSM state enum.
- Sub-module mem_lane_align: combinational byte-enable, write replication, read lane extraction, parametrised by DATA_W.

## Test plan
- ALU op, alu_data_i=0x1234, inst[15:12]=3 -> next cycle alu_data_o=0x1234, wb_addr_o=3, valid_o=1, no stall.
- STRB addr 0x102, data 0xAB, gnt same cycle -> be=0100, wdata=0xABABABAB, addr 0x100, no stall.
- LDR addr 0x200, gnt cycle 0, rvalid cycle 3 data 0xDEADBEEF -> stall 3 cycles, mem_data_o=0xDEADBEEF, load_o=1.
- LDRB addr 0x203, rdata 0x11223344 -> mem_data_o=0x00000011.
- Load in WAIT_RSP, flush_i pulsed, rvalid 2 cycles later -> valid_o=0, stall clears after rvalid.
- Reset asserted in WAIT_RSP, late rvalid -> all outputs 0, state IDLE, rvalid ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, memory opcode and MEM-stage FSM states.
package cpu_pkg;

    localparam int unsigned INST_OPC_HI = 27;
    localparam int unsigned INST_OPC_LO = 26;
    localparam int unsigned INST_B_BIT  = 22;
    localparam int unsigned INST_L_BIT  = 20;
    localparam int unsigned INST_RD_HI  = 15;
    localparam int unsigned INST_RD_LO  = 12;

    localparam logic [1:0] OPC_MEM = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StWaitRsp,
        StDrain
    } mem_state_e;

    function automatic logic is_mem_op(input logic [31:0] inst);
        return inst[INST_OPC_HI:INST_OPC_LO] == OPC_MEM;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data-memory port: byte enables, store replication and
// load lane extraction (zero-extended for byte accesses).
module mem_lane_align #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LB     = $clog2(DATA_W / 8)
) (
    input  logic [LB-1:0]       addr_lo_i,
    input  logic                byte_i,
    input  logic [DATA_W-1:0]   store_data_i,
    input  logic [DATA_W-1:0]   rdata_i,
    output logic [DATA_W/8-1:0] be_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int unsigned NB = DATA_W / 8;

    always_comb begin
        be_o    = '0;
        wdata_o = '0;
        rdata_o = '0;
        if (byte_i) begin
            be_o[addr_lo_i] = 1'b1;
            for (int i = 0; i < NB; i++) begin
                wdata_o[i*8 +: 8] = store_data_i[7:0];
                if (addr_lo_i == LB'(i)) begin
                    rdata_o[7:0] = rdata_i[i*8 +: 8];
                end
            end
        end else begin
            be_o    = '1;
            wdata_o = store_data_i;
            rdata_o = rdata_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one data-memory access at a time, stalls upstream
// until it completes and registers results for writeback.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_W  = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [DATA_W-1:0]   alu_data_i,
    input  logic [DATA_W-1:0]   store_data_i,
    input  logic [31:0]         inst_i,
    input  logic                valid_i,
    input  logic                do_write_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [ADDR_W-1:0]   dmem_addr_o,
    output logic [DATA_W-1:0]   dmem_wdata_o,
    output logic [DATA_W/8-1:0] dmem_be_o,
    input  logic                dmem_gnt_i,
    input  logic                dmem_rvalid_i,
    input  logic [DATA_W-1:0]   dmem_rdata_i,
    output logic [DATA_W-1:0]   alu_data_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic [REG_W-1:0]    wb_addr_o,
    output logic                valid_o,
    output logic                do_write_o,
    output logic                load_o,
    output logic                flush_o
);

    localparam int unsigned LB = $clog2(DATA_W / 8);

    mem_state_e r_state;
    mem_state_e w_state_d;

    logic              w_mem_op;
    logic              w_load;
    logic              w_byte;
    logic              w_active;
    logic              w_stall;
    logic              w_load_done;
    logic              w_drop;
    logic              w_valid_in;
    logic [DATA_W-1:0] w_rdata_al;
    logic [ADDR_W-1:0] w_addr;
    logic              w_unused_inst;

    logic [DATA_W-1:0] r_alu_data;
    logic [DATA_W-1:0] r_mem_data;
    logic [REG_W-1:0]  r_wb_addr;
    logic              r_valid;
    logic              r_do_write;
    logic              r_load;
    logic              r_flush;

    assign w_mem_op      = is_mem_op(inst_i);
    assign w_load        = inst_i[INST_L_BIT];
    assign w_byte        = inst_i[INST_B_BIT];
    assign w_active      = valid_i & w_mem_op & ~flush_i;
    assign w_unused_inst = ^inst_i;

    // Lane-aligned address; alu_data_i is zero-extended or truncated to ADDR_W.
    always_comb begin
        w_addr = '0;
        for (int i = 0; i < int'(ADDR_W) && i < int'(DATA_W); i++) begin
            w_addr[i] = alu_data_i[i];
        end
        w_addr[LB-1:0] = '0;
    end

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .addr_lo_i    (alu_data_i[LB-1:0]),
        .byte_i       (w_byte),
        .store_data_i (store_data_i),
        .rdata_i      (dmem_rdata_i),
        .be_o         (dmem_be_o),
        .wdata_o      (dmem_wdata_o),
        .rdata_o      (w_rdata_al)
    );

    assign dmem_addr_o = w_addr;
    assign dmem_we_o   = w_active & ~w_load;

    // The response cycle itself is not stalled so results capture on the edge ending it.
    always_comb begin
        w_state_d   = r_state;
        dmem_req_o  = 1'b0;
        w_stall     = 1'b0;
        w_load_done = 1'b0;
        w_drop      = 1'b0;
        unique case (r_state)
            StIdle: begin
                dmem_req_o = w_active;
                if (w_active) begin
                    if (dmem_gnt_i && w_load) begin
                        w_state_d = StWaitRsp;
                    end
                    if (!(dmem_gnt_i && !w_load)) begin
                        w_stall = 1'b1;
                    end
                end
            end
            StWaitRsp: begin
                if (dmem_rvalid_i) begin
                    w_state_d   = StIdle;
                    w_load_done = 1'b1;
                end else begin
                    w_stall = 1'b1;
                    if (flush_i) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (dmem_rvalid_i) begin
                    w_state_d = StIdle;
                    w_drop    = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign stall_o    = w_stall;
    assign w_valid_in = valid_i & ~flush_i & ~w_drop;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_alu_data <= '0;
            r_mem_data <= '0;
            r_wb_addr  <= '0;
            r_valid    <= 1'b0;
            r_do_write <= 1'b0;
            r_load     <= 1'b0;
            r_flush    <= 1'b0;
        end else begin
            r_flush <= flush_i;
            if (!w_stall) begin
                r_alu_data <= alu_data_i;
                r_wb_addr  <= inst_i[INST_RD_LO +: REG_W];
                r_valid    <= w_valid_in;
                r_do_write <= do_write_i & w_valid_in & ~(w_mem_op & ~w_load);
                r_load     <= w_valid_in & w_mem_op & w_load;
                if (w_load_done && !flush_i) begin
                    r_mem_data <= w_rdata_al;
                end
            end else begin
                r_valid    <= 1'b0;
                r_do_write <= 1'b0;
                r_load     <= 1'b0;
            end
        end
    end

    assign alu_data_o = r_alu_data;
    assign mem_data_o = r_mem_data;
    assign wb_addr_o  = r_wb_addr;
    assign valid_o    = r_valid;
    assign do_write_o = r_do_write;
    assign load_o     = r_load;
    assign flush_o    = r_flush;

endmodule
